blink_monitor: RTL and testbench

- Reader-side companion to the LED blink generator. It samples an asynchronous blink/LED line and measures period and high time in clk cycles.
- Reports each completed period with a one-cycle valid strobe.
- Flags a stuck line when no edge occurs within a timeout.
- Sits beside the blink generator on the board for self-check, or on any blink/heartbeat input.

---
 rtl/blink_monitor.sv | 115 +++++++++++
 tb/tb_blink_monitor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/blink_monitor.sv
`timescale 1ns/100ps
// blink_monitor: measures rising-to-rising period and high time of an
// asynchronous blink line, and flags a line that has stopped toggling.
module blink_monitor #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             led_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             stuck,
    output logic             stuck_level
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;

    localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic             s1, s2, d;
    logic             rise, fall, any_edge, timeout_hit;
    logic [CNT_W-1:0] cnt, hi_lat, tcnt;
    logic [1:0]       state;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign rise        = s2 & ~d;
    assign fall        = ~s2 & d;
    assign any_edge    = rise | fall;
    assign timeout_hit = ~any_edge & (tcnt == TO_LAST);

    // Synchronizer stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            d  <= 1'b0;
        end else begin
            s1 <= led_in;
            s2 <= s1;
            d  <= s2;
        end
    end

    // Measurement counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            hi_lat <= '0;
        end else begin
            cnt <= rise ? CNT_W'(1) : sat_inc(cnt);
            if (fall)
                hi_lat <= cnt;
            else if (timeout_hit)
                hi_lat <= '0;
        end
    end

    // Edge timeout stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt        <= '0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            if (any_edge)
                tcnt <= '0;
            else if (tcnt != TO_MAX)
                tcnt <= tcnt + CNT_W'(1);

            if (any_edge) begin
                stuck <= 1'b0;
            end else if (timeout_hit) begin
                stuck       <= 1'b1;
                stuck_level <= s2;
            end
        end
    end

    // Period FSM and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (timeout_hit) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (rise) state <= HIGH;
                    HIGH: if (fall) state <= LOW;
                    LOW: begin
                        if (rise) begin
                            state      <= HIGH;
                            period     <= cnt;
                            high_time  <= hi_lat;
                            meas_valid <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_blink_monitor.sv
`timescale 1ns/100ps
// Self-checking bench for blink_monitor: table-driven square waves, stuck and
// reset corner cases, random patterns against an event-level model, async phase.
module tb_blink_monitor;
    localparam int T = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        led_a = 1'b0;
    logic        led_b = 1'b0;
    logic [31:0] period, high_time, period_l, high_l;
    logic        meas_valid, stuck, stuck_level, mv_l, stuck_l, slvl_l;

    blink_monitor #(.CNT_W(32), .TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .led_in(led_a),
        .period(period), .high_time(high_time), .meas_valid(meas_valid),
        .stuck(stuck), .stuck_level(stuck_level)
    );

    blink_monitor #(.CNT_W(32), .TIMEOUT(2000)) dut_l (
        .clk(clk), .rst_n(rst_n), .led_in(led_b),
        .period(period_l), .high_time(high_l), .meas_valid(mv_l),
        .stuck(stuck_l), .stuck_level(slvl_l)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int lo;
        int reps;
        int exp_p;
        int exp_h;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Event-level reference model: input transitions are detected two samples
    // after they are first sampled; measurements come from detected edge times.
    int          n, last_edge;
    logic        last_lvl, det_lvl;
    int          pend_t[$];
    logic        pend_v[$];
    int          ev_t[$];
    logic        ev_v[$];
    logic        e_mv, e_st, e_sl;
    logic [31:0] e_p, e_h;

    logic [31:0] cap_p, cap_h;
    int          nval;
    logic        mon_l = 1'b0;
    int          nval_l = 0;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s n=%0d got=%h want=%h", name, n, got, exp);
        end
    endtask

    task automatic model_reset();
        n = 0; last_edge = 0; last_lvl = 1'b0; det_lvl = 1'b0;
        pend_t.delete(); pend_v.delete(); ev_t.delete(); ev_v.delete();
        e_mv = 1'b0; e_st = 1'b0; e_sl = 1'b0; e_p = '0; e_h = '0;
    endtask

    task automatic model_sample(input logic v);
        logic hit, lvl;
        int   sz;
        n++;
        e_mv = 1'b0;
        hit  = 1'b0;
        lvl  = 1'b0;
        if (v !== last_lvl) begin
            pend_t.push_back(n + 2);
            pend_v.push_back(v);
            last_lvl = v;
        end
        if (pend_t.size() > 0 && pend_t[0] == n) begin
            hit = 1'b1;
            lvl = pend_v[0];
            void'(pend_t.pop_front());
            void'(pend_v.pop_front());
        end
        if (hit) begin
            sz = ev_t.size();
            if (lvl && sz >= 2 && !ev_v[sz-1] && ev_v[sz-2] &&
                (n - ev_t[sz-1] <= T) && (ev_t[sz-1] - ev_t[sz-2] <= T)) begin
                e_mv = 1'b1;
                e_p  = 32'(n - ev_t[sz-2]);
                e_h  = 32'(ev_t[sz-1] - ev_t[sz-2]);
            end
            ev_t.push_back(n);
            ev_v.push_back(lvl);
            last_edge = n;
            det_lvl   = lvl;
            e_st      = 1'b0;
        end else if (n - last_edge == T) begin
            e_st = 1'b1;
            e_sl = det_lvl;
        end
    endtask

    task automatic step(input logic v, input logic rel);
        @(negedge clk);
        if (rel) rst_n = 1'b1;
        led_a = v;
        @(posedge clk);
        #1;
        model_sample(v);
        check("cycle", {meas_valid, stuck, stuck_level, period, high_time},
              {e_mv, e_st, e_sl, e_p, e_h});
        if (meas_valid) begin
            cap_p = period;
            cap_h = high_time;
            nval++;
        end
    endtask

    task automatic pulse_pair(input int hi, input int lo);
        repeat (hi) step(1'b1, 1'b0);
        repeat (lo) step(1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_l && mv_l) begin
            nval_l++;
            checks++;
            if (period_l < 32'd999 || period_l > 32'd1001 || high_l < 32'd499 || high_l > 32'd501) begin
                errors++;
                $display("FAIL async_meas got period=%0d high=%0d want 1000+-1/500+-1", period_l, high_l);
            end
        end
    end

    vec_t tbl[3];
    int   nval0, cur, nx, len;
    logic lvl_r;

    initial begin
        tbl[0] = '{4, 6, 5, 10, 4};
        tbl[1] = '{3, 3, 4, 6, 3};
        tbl[2] = '{7, 1, 4, 8, 7};
        cap_p = '0; cap_h = '0; nval = 0;
        model_reset();

        // Reset held while the line toggles
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            led_a = i[0];
            @(posedge clk);
            #1;
            check("reset_hold", {meas_valid, stuck, stuck_level, period, high_time}, '0);
        end
        model_reset();
        step(1'b0, 1'b1);

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < tbl[r].reps; k++) pulse_pair(tbl[r].hi, tbl[r].lo);
            check($sformatf("table%0d", r), {cap_p, cap_h}, {32'(tbl[r].exp_p), 32'(tbl[r].exp_h)});
        end

        // Stuck high: rise detected on the 3rd sample, stuck 20 samples later
        for (int i = 1; i <= 30; i++) begin
            step(1'b1, 1'b0);
            if (i == 22) check("stuck_early", {stuck}, 1'b0);
            if (i == 23) check("stuck_set", {stuck, stuck_level}, 2'b11);
        end
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b0);
            if (i == 2) check("stuck_hold", {stuck}, 1'b1);
            if (i == 3) check("stuck_clear", {stuck}, 1'b0);
        end
        nval0 = nval;
        pulse_pair(4, 6);
        pulse_pair(4, 6);
        check("stuck_recover_cnt", 96'(nval - nval0), 96'd1);
        check("stuck_recover_val", {cap_p, cap_h}, {32'd10, 32'd4});

        // Async reset between a fall and the next rise
        pulse_pair(4, 6);
        pulse_pair(4, 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst", {meas_valid, stuck, stuck_level, period, high_time}, '0);
        model_reset();
        @(posedge clk);
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        nval0 = nval;
        pulse_pair(4, 6);
        pulse_pair(4, 6);
        check("rst_mid_cnt", 96'(nval - nval0), 96'd1);
        check("rst_mid_val", {cap_p, cap_h}, {32'd10, 32'd4});

        // Random high/low lengths, some longer than the timeout
        lvl_r = 1'b1;
        for (int ph = 0; ph < 40; ph++) begin
            len = $urandom_range(1, 26);
            repeat (len) step(lvl_r, 1'b0);
            lvl_r = ~lvl_r;
        end

        // Asynchronous phase offsets on the long-timeout instance
        @(posedge clk);
        #0.5;
        mon_l = 1'b1;
        cur = 0;
        for (int i = 0; i < 24; i++) begin
            nx = $urandom_range(0, 90);
            #(5000.0 + real'(nx - cur) / 10.0);
            led_b = ~led_b;
            cur = nx;
        end
        repeat (20) @(posedge clk);
        mon_l = 1'b0;
        check("async_count", 96'(nval_l), 96'd11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
